// File: rtl/zamanlayici_denetleyici.sv
// Wishbone-slave timer: prescaled 32-bit up-counter with compare, optional
// auto-reload and a level interrupt.
module zamanlayici_denetleyici #(
  parameter logic [15:0] BOLUCU_SIFIRLAMA = 16'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        kesme_o
);
  logic [2:0]  kontrol;
  logic [15:0] bolucu, on_sayac;
  logic [31:0] sayac, karsilastirma, sonraki, okunan;
  logic        eslesme;
  logic        istek, yaz, tik, eslesti;
  logic        kontrol_yaz, bolucu_yaz, sayac_yaz, karsi_yaz, durum_temizle;
  logic [2:0]  kelime;
  logic        unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];

  // A request is taken only while no ack is outstanding, so a held strobe
  // is served every other cycle.
  assign istek  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign yaz    = istek & wb_we_i;
  assign kelime = wb_adr_i[4:2];

  assign kontrol_yaz   = yaz && (kelime == 3'd0);
  assign bolucu_yaz    = yaz && (kelime == 3'd1);
  assign sayac_yaz     = yaz && (kelime == 3'd2);
  assign karsi_yaz     = yaz && (kelime == 3'd3);
  assign durum_temizle = yaz && (kelime == 3'd4) && wb_sel_i[0] && wb_dat_i[0];

  function automatic logic [31:0] bayt_birlestir(input logic [31:0] eski,
                                                 input logic [31:0] yeni,
                                                 input logic [3:0]  sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = sel[i] ? yeni[8*i +: 8] : eski[8*i +: 8];
    return r;
  endfunction

  assign tik     = kontrol[0] && (on_sayac == bolucu);
  assign sonraki = sayac + 32'd1;
  // A bus write to sayac swallows the tick, including its match.
  assign eslesti = tik && !sayac_yaz && (sonraki == karsilastirma);

  always_comb begin
    okunan = '0;
    case (kelime)
      3'd0:    okunan = {29'b0, kontrol};
      3'd1:    okunan = {16'b0, bolucu};
      3'd2:    okunan = sayac;
      3'd3:    okunan = karsilastirma;
      3'd4:    okunan = {31'b0, eslesme};
      default: okunan = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= istek;
      if (istek && !wb_we_i) wb_dat_o <= okunan;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kontrol       <= '0;
      bolucu        <= BOLUCU_SIFIRLAMA;
      karsilastirma <= 32'hFFFF_FFFF;
    end else begin
      if (kontrol_yaz && wb_sel_i[0]) kontrol <= wb_dat_i[2:0];
      if (bolucu_yaz && wb_sel_i[0])  bolucu[7:0]  <= wb_dat_i[7:0];
      if (bolucu_yaz && wb_sel_i[1])  bolucu[15:8] <= wb_dat_i[15:8];
      if (karsi_yaz) karsilastirma <= bayt_birlestir(karsilastirma, wb_dat_i, wb_sel_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      on_sayac <= '0;
    else if (bolucu_yaz || !kontrol[0] || tik) on_sayac <= '0;
    else                            on_sayac <= on_sayac + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          sayac <= '0;
    else if (sayac_yaz) sayac <= bayt_birlestir(sayac, wb_dat_i, wb_sel_i);
    else if (tik)       sayac <= (eslesti && kontrol[1]) ? 32'd0 : sonraki;
  end

  // Set has priority over write-1-clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              eslesme <= 1'b0;
    else if (eslesti)       eslesme <= 1'b1;
    else if (durum_temizle) eslesme <= 1'b0;
  end

  assign kesme_o = eslesme & kontrol[2];
endmodule
